fifo_pkt_reader: RTL and testbench

- Read-side controller for the team's 8-bit byte FIFO.
- Pops bytes from the FIFO using its remove/empty handshake and frames them into length-prefixed packets.
- Presents each packet on a valid/ready byte stream for downstream consumers.
- Runs entirely in the FIFO read clock domain.

---
 rtl/fifo_pkt_reader.sv | 196 +++++++++++++++++++
 tb/tb_fifo_pkt_reader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pkt_reader.sv
// fifo_pkt_reader: read-side controller for the 8-bit byte FIFO.
// Pops a length header L (1..255), then L payload bytes, and presents them
// on a valid/ready byte stream. There is only one pop in flight at a time.
// Optional feature: define PKT_READER_TIMEOUT_EN to abandon a packet after
// TIMEOUT consecutive empty cycles while waiting for payload (err_timeout).
module fifo_pkt_reader #(
   parameter int RD_LAT  = 2,
   parameter int TIMEOUT = 64
) (
   input  logic        clk_out,
   input  logic        reset,
   input  logic        flush,
   input  logic        empty,
   input  logic [7:0]  fifo_data,
   output logic        remove,
   output logic [7:0]  pkt_data,
   output logic        pkt_valid,
   input  logic        pkt_ready,
   output logic        pkt_last,
   output logic [15:0] pkt_count,
   output logic        err_zero_len,
   output logic        err_timeout
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_REQ_HDR   = 3'd1,
      S_WAIT_HDR  = 3'd2,
      S_REQ_DATA  = 3'd3,
      S_WAIT_DATA = 3'd4,
      S_SEND      = 3'd5
   } state_t;

   // Last value of the read-latency counter: the cycle fifo_data is valid.
   localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

   state_t      state_q, state_d;
   logic [2:0]  lat_q, lat_d;
   logic [7:0]  remaining_q, remaining_d;
   logic [7:0]  hold_q, hold_d;
   logic [15:0] count_q, count_d;
   logic        zero_len_q, zero_len_d;
   logic        lat_done_s;
   logic        timeout_hit_s;

   assign lat_done_s = (lat_q == LAT_LAST);

   // State register.
   always_ff @(posedge clk_out or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; flush overrides every transition.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:      state_d = S_REQ_HDR;
            S_REQ_HDR:   state_d = empty ? S_REQ_HDR : S_WAIT_HDR;
            S_WAIT_HDR: begin
               if (lat_done_s) begin
                  state_d = (fifo_data == 8'd0) ? S_IDLE : S_REQ_DATA;
               end else begin
                  state_d = S_WAIT_HDR;
               end
            end
            S_REQ_DATA: begin
               if (timeout_hit_s) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = empty ? S_REQ_DATA : S_WAIT_DATA;
               end
            end
            S_WAIT_DATA: state_d = lat_done_s ? S_SEND : S_WAIT_DATA;
            S_SEND: begin
               if (pkt_ready) begin
                  state_d = (remaining_q == 8'd1) ? S_IDLE : S_REQ_DATA;
               end else begin
                  state_d = S_SEND;
               end
            end
            default:     state_d = S_IDLE;
         endcase
      end
   end

   // Outputs decoded from state; a pop is suppressed while flushing so the
   // byte stays in the FIFO for the next header read.
   always_comb begin
      remove    = 1'b0;
      pkt_valid = 1'b0;
      pkt_last  = 1'b0;
      if (state_q == S_REQ_HDR || state_q == S_REQ_DATA) begin
         remove = !empty && !flush;
      end else if (state_q == S_SEND) begin
         pkt_valid = 1'b1;
         pkt_last  = (remaining_q == 8'd1);
      end else begin
         remove = 1'b0;
      end
   end

   assign pkt_data     = hold_q;
   assign pkt_count    = count_q;
   assign err_zero_len = zero_len_q;

   // Datapath next-state: latency counter, header/payload capture, counters.
   always_comb begin
      lat_d       = 3'd0;
      remaining_d = remaining_q;
      hold_d      = hold_q;
      count_d     = count_q;
      zero_len_d  = zero_len_q;
      if (!flush && (state_q == S_WAIT_HDR || state_q == S_WAIT_DATA) && !lat_done_s) begin
         lat_d = lat_q + 3'd1;
      end else begin
         lat_d = 3'd0;
      end
      if (flush) begin
         remaining_d = remaining_q;
      end else if (state_q == S_WAIT_HDR && lat_done_s) begin
         remaining_d = fifo_data;
         zero_len_d  = zero_len_q | (fifo_data == 8'd0);
      end else if (state_q == S_WAIT_DATA && lat_done_s) begin
         hold_d = fifo_data;
      end else if (state_q == S_SEND && pkt_ready) begin
         remaining_d = remaining_q - 8'd1;
         if (remaining_q == 8'd1) begin
            count_d = count_q + 16'd1;
         end else begin
            count_d = count_q;
         end
      end else begin
         remaining_d = remaining_q;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk_out or posedge reset) begin
      if (reset) begin
         lat_q       <= 3'd0;
         remaining_q <= 8'd0;
         hold_q      <= 8'd0;
         count_q     <= 16'd0;
         zero_len_q  <= 1'b0;
      end else begin
         lat_q       <= lat_d;
         remaining_q <= remaining_d;
         hold_q      <= hold_d;
         count_q     <= count_d;
         zero_len_q  <= zero_len_d;
      end
   end

`ifdef PKT_READER_TIMEOUT_EN
   localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT - 1);

   logic [15:0] idle_q, idle_d;
   logic        timeout_q, timeout_d;

   assign timeout_hit_s = (state_q == S_REQ_DATA) && empty && !flush && (idle_q == IDLE_LAST);
   assign err_timeout   = timeout_q;

   // Idle counter runs only while stalled in REQ_DATA; cleared on exit.
   always_comb begin
      idle_d    = 16'd0;
      timeout_d = timeout_q | timeout_hit_s;
      if (state_q == S_REQ_DATA && state_d == S_REQ_DATA && empty) begin
         idle_d = idle_q + 16'd1;
      end else begin
         idle_d = 16'd0;
      end
   end

   // Idle counter and sticky timeout flag.
   always_ff @(posedge clk_out or posedge reset) begin
      if (reset) begin
         idle_q    <= 16'd0;
         timeout_q <= 1'b0;
      end else begin
         idle_q    <= idle_d;
         timeout_q <= timeout_d;
      end
   end
`else
   assign timeout_hit_s = 1'b0;
   assign err_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Scoreboard bench for fifo_pkt_reader: a FIFO model feeds the DUT, the
// stimulus thread loads bytes and queues expected packet bytes, and the
// monitor thread checks every accepted byte plus protocol rules.
module tb_fifo_pkt_reader;
   localparam int RD_LAT  = 2;
   localparam int TIMEOUT = 8;

   logic        clk_out = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        empty;
   logic [7:0]  fifo_data;
   logic        remove;
   logic [7:0]  pkt_data;
   logic        pkt_valid;
   logic        pkt_ready = 1'b0;
   logic        pkt_last;
   logic [15:0] pkt_count;
   logic        err_zero_len;
   logic        err_timeout;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int remove_cnt = 0;
   logic [8:0] exp_q[$];
   int acc_cyc[$];

   // FIFO model state
   logic [7:0] mem [0:255];
   int wr_ptr = 0;
   int rd_ptr = 0;
   logic stall_empty = 1'b0;
   logic [7:0] pipe [1:RD_LAT];

   fifo_pkt_reader #(.RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
      .clk_out(clk_out), .reset(reset), .flush(flush), .empty(empty),
      .fifo_data(fifo_data), .remove(remove), .pkt_data(pkt_data),
      .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_last(pkt_last),
      .pkt_count(pkt_count), .err_zero_len(err_zero_len), .err_timeout(err_timeout)
   );

   always #5 clk_out = ~clk_out;

   always @(posedge clk_out) cyc <= cyc + 1;

   assign empty     = (rd_ptr == wr_ptr) || stall_empty;
   assign fifo_data = pipe[RD_LAT];

   // FIFO model: popped byte appears on fifo_data RD_LAT cycles after remove.
   always @(posedge clk_out or posedge reset) begin
      if (reset) begin
         rd_ptr <= wr_ptr;
         for (int i = 1; i <= RD_LAT; i++) pipe[i] <= 8'hEE;
      end else begin
         if (remove && (rd_ptr != wr_ptr)) begin
            pipe[1] <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + 1;
         end else begin
            pipe[1] <= 8'hEE;
         end
         for (int i = 2; i <= RD_LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_out);
      #1;
   endtask

   task automatic load(input logic [7:0] b);
      mem[wr_ptr] = b;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic expect_byte(input logic [7:0] d, input logic l);
      exp_q.push_back({l, d});
   endtask

   // Returns at the negedge where pkt_valid is seen (optionally with data d).
   task automatic wait_valid(input string name, input logic match, input logic [7:0] d);
      int b = 0;
      @(negedge clk_out);
      while (!(pkt_valid && (!match || pkt_data == d)) && b < 300) begin
         @(negedge clk_out);
         b++;
      end
      check({name, "_wait_valid_timeout"}, (b < 300), 1'b1);
   endtask

   task automatic drain(input string name);
      int b = 0;
      while (exp_q.size() != 0 && b < 500) begin
         tick(1);
         b++;
      end
      check({name, "_drain_pending"}, exp_q.size(), 0);
      tick(3);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_remove"}, remove, 1'b0);
      check({name, "_pkt_valid"}, pkt_valid, 1'b0);
      check({name, "_pkt_last"}, pkt_last, 1'b0);
      check({name, "_pkt_data"}, pkt_data, 8'h00);
      check({name, "_pkt_count"}, pkt_count, 16'd0);
      check({name, "_err_zero_len"}, err_zero_len, 1'b0);
      check({name, "_err_timeout"}, err_timeout, 1'b0);
   endtask

   task automatic monitor();
      logic prev_acc = 1'b0;
      logic prev_hold = 1'b0;
      logic [7:0] prev_data = 8'h00;
      logic [8:0] e;
      forever begin
         @(negedge clk_out);
         if (remove) begin
            remove_cnt++;
            check("remove_while_empty", empty, 1'b0);
         end
         if (pkt_last) check("last_without_valid", pkt_valid, 1'b1);
         if (prev_acc && !reset) check("valid_after_accept", pkt_valid, 1'b0);
         if (prev_hold && !reset) begin
            check("hold_valid", pkt_valid, 1'b1);
            check("hold_data", pkt_data, prev_data);
         end
         prev_acc  = pkt_valid && pkt_ready && !flush;
         prev_hold = pkt_valid && !pkt_ready && !flush && !reset;
         prev_data = pkt_data;
         if (pkt_valid && pkt_ready && !flush && !reset) begin
            acc_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_byte: got data %0h last %0b, none expected", pkt_data, pkt_last);
            end else begin
               e = exp_q.pop_front();
               check("pkt_data", pkt_data, e[7:0]);
               check("pkt_last", pkt_last, e[8]);
            end
         end
      end
   endtask

   task automatic stimulus();
      int rc0;
      // Reset state
      @(negedge clk_out);
      check_reset_outputs("reset");
      tick(1);
      reset = 1'b0;
      tick(2);

      // T1: 03 AA BB CC with continuous ready
      pkt_ready = 1'b1;
      rc0 = remove_cnt;
      acc_cyc.delete();
      load(8'h03); load(8'hAA); load(8'hBB); load(8'hCC);
      expect_byte(8'hAA, 1'b0); expect_byte(8'hBB, 1'b0); expect_byte(8'hCC, 1'b1);
      drain("t1");
      check("t1_remove_pulses", remove_cnt - rc0, 4);
      check("t1_pkt_count", pkt_count, 16'd1);
      check("t1_accept_count", acc_cyc.size(), 3);
      if (acc_cyc.size() == 3) begin
         check("t1_byte_period_1", acc_cyc[1] - acc_cyc[0], RD_LAT + 2);
         check("t1_byte_period_2", acc_cyc[2] - acc_cyc[1], RD_LAT + 2);
      end

      // T2: back-pressure for 5 cycles on the first byte
      pkt_ready = 1'b0;
      load(8'h02); load(8'h11); load(8'h22);
      expect_byte(8'h11, 1'b0); expect_byte(8'h22, 1'b1);
      wait_valid("t2", 1'b0, 8'h00);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk_out);
         check("t2_hold_valid", pkt_valid, 1'b1);
         check("t2_hold_data", pkt_data, 8'h11);
         check("t2_no_remove", remove, 1'b0);
      end
      tick(1);
      pkt_ready = 1'b1;
      drain("t2");
      check("t2_pkt_count", pkt_count, 16'd2);

      // T3: asynchronous reset mid-packet clears everything
      pkt_ready = 1'b0;
      load(8'h02); load(8'hE1); load(8'hE2);
      wait_valid("t3", 1'b0, 8'h00);
      #2;
      reset = 1'b1;
      #1;
      check_reset_outputs("t3_async_reset");
      tick(2);
      reset = 1'b0;
      tick(2);

      // T4: zero-length header, then a one-byte packet
      pkt_ready = 1'b1;
      load(8'h00); load(8'h01); load(8'h55);
      expect_byte(8'h55, 1'b1);
      drain("t4");
      check("t4_err_zero_len", err_zero_len, 1'b1);
      check("t4_pkt_count", pkt_count, 16'd1);

      // T5: flush after the 2nd payload byte; next FIFO byte is a header
      load(8'h04); load(8'hA1); load(8'hA2); load(8'h02); load(8'hB1); load(8'hB2);
      expect_byte(8'hA1, 1'b0); expect_byte(8'hA2, 1'b0);
      expect_byte(8'hB1, 1'b0); expect_byte(8'hB2, 1'b1);
      wait_valid("t5", 1'b1, 8'hA2);
      tick(1);
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      @(negedge clk_out);
      check("t5_valid_after_flush", pkt_valid, 1'b0);
      check("t5_remove_after_flush", remove, 1'b0);
      check("t5_count_after_flush", pkt_count, 16'd1);
      drain("t5");
      check("t5_pkt_count", pkt_count, 16'd2);
      check("t5_err_zero_len_kept", err_zero_len, 1'b1);

      // T6: flush and acceptance in the same cycle; flush wins
      pkt_ready = 1'b0;
      load(8'h01); load(8'hC1);
      wait_valid("t6", 1'b0, 8'h00);
      tick(1);
      pkt_ready = 1'b1;
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      @(negedge clk_out);
      check("t6_valid_after_flush", pkt_valid, 1'b0);
      tick(3);
      check("t6_pkt_count", pkt_count, 16'd2);

      // T7: empty held high for 3 cycles mid-packet
      load(8'h03); load(8'hD1); load(8'hD2); load(8'hD3);
      expect_byte(8'hD1, 1'b0); expect_byte(8'hD2, 1'b0); expect_byte(8'hD3, 1'b1);
      wait_valid("t7", 1'b1, 8'hD1);
      tick(1);
      stall_empty = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_out);
         check("t7_no_remove_when_empty", remove, 1'b0);
      end
      tick(1);
      stall_empty = 1'b0;
      drain("t7");
      check("t7_pkt_count", pkt_count, 16'd3);

`ifdef PKT_READER_TIMEOUT_EN
      // T8: header 03 with only one payload byte -> timeout
      tick(1);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(2);
      load(8'h03); load(8'hF1);
      expect_byte(8'hF1, 1'b0);
      wait_valid("t8", 1'b1, 8'hF1);
      for (int i = 0; i < TIMEOUT; i++) begin
         @(negedge clk_out);
         check("t8_no_early_timeout", err_timeout, 1'b0);
      end
      @(negedge clk_out);
      check("t8_err_timeout", err_timeout, 1'b1);
      tick(3);
      check("t8_pkt_count", pkt_count, 16'd0);
      #2;
      reset = 1'b1;
      #1;
      check("t8_reset_clears_timeout", err_timeout, 1'b0);
      tick(1);
      reset = 1'b0;
      tick(2);
`else
      check("err_timeout_tied_low", err_timeout, 1'b0);
`endif
      check("final_pending_bytes", exp_q.size(), 0);
   endtask

   initial begin
      fork
         monitor();
         stimulus();
      join_any
      disable fork;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
